// File: rtl/unpacked_array_packer_pkg.sv
// unpacked_array_pkg
//   Shared definitions for the unpacked-array packer: default lane geometry,
//   the lane type at default sizes, the FIFO occupancy encoding and a helper
//   that packs an unpacked lane array into a flat vector (lane 0 in the LSBs).
//   No ports.
package unpacked_array_pkg;

    localparam int N_DEF  = 4;
    localparam int W_DEF  = 8;
    localparam int CW_DEF = 16;

    typedef logic [W_DEF-1:0] lane_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [N_DEF*W_DEF-1:0] pack_lanes(input lane_t lanes [0:N_DEF-1]);
        logic [N_DEF*W_DEF-1:0] w;
        w = '0;
        for (int i = 0; i < N_DEF; i++) begin
            w[i*W_DEF +: W_DEF] = lanes[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/unpacked_array_packer_if.sv
// unpacked_array_packer_if
//   Handshake and data bundle between a producer of unpacked lane arrays, the
//   packer, and a packed-bus consumer.
//   master : producer/consumer side (drives in_valid, in_data, in_mask, out_ready)
//   slave  : packer side (drives in_ready, out_valid, out_data, xfer_count)
interface unpacked_array_packer_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data [0:N-1];
    logic             in_mask [0:N-1];
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_data;
    logic [CW-1:0]    xfer_count;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, xfer_count
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, xfer_count
    );
endinterface

// File: rtl/packed_skid_fifo.sv
// packed_skid_fifo
//   Two-entry FIFO holding packed words. dout is the head entry; it keeps the
//   last popped word while empty, and is cleared by reset.
//   Ports: clock, reset (sync, active-high), push/din, pop/dout, full, empty.
//   Pushes while full and pops while empty are ignored.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   OCC_EMPTY | no entries; wr_ptr == rd_ptr
//   OCC_ONE   | head at rd_ptr; wr_ptr == ~rd_ptr
//   OCC_FULL  | both entries valid; head at rd_ptr
module packed_skid_fifo
    import unpacked_array_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    occ_e          state_q, state_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] mem_q [0:1];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (state_q != OCC_FULL);
    assign do_pop  = pop  && (state_q != OCC_EMPTY);

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            OCC_EMPTY: begin
                if (do_push) begin
                    state_d  = OCC_ONE;
                    wr_ptr_d = ~wr_ptr_q;
                end
            end
            OCC_ONE: begin
                if (do_push && do_pop) begin
                    rd_ptr_d = ~rd_ptr_q;
                    wr_ptr_d = ~wr_ptr_q;
                end else if (do_push) begin
                    state_d  = OCC_FULL;
                    wr_ptr_d = ~wr_ptr_q;
                end else if (do_pop) begin
                    // Leave rd_ptr on the popped entry so dout holds its last
                    // value; the next push lands in that same slot.
                    state_d  = OCC_EMPTY;
                    wr_ptr_d = rd_ptr_q;
                end
            end
            OCC_FULL: begin
                if (do_pop) begin
                    state_d  = OCC_ONE;
                    rd_ptr_d = ~rd_ptr_q;
                end
            end
            default: begin
                state_d  = OCC_EMPTY;
                rd_ptr_d = 1'b0;
                wr_ptr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= OCC_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (state_q == OCC_FULL);
    assign empty = (state_q == OCC_EMPTY);

endmodule

// File: rtl/unpacked_array_packer.sv
// unpacked_array_packer
//   Accepts an unpacked array of N lanes (W bits each) with a per-lane update
//   mask, merges masked lanes with held lane values, packs the result
//   (lane i -> bits [i*W +: W]) and queues it in a 2-entry FIFO.
//   Ports: clock, reset (sync, active-high), bus (slave modport carrying
//   in_valid/in_ready/in_data/in_mask, out_valid/out_ready/out_data and the
//   output handshake counter xfer_count).
module unpacked_array_packer
    import unpacked_array_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    unpacked_array_packer_if.slave bus
);
    logic [W-1:0]   hold_q [0:N-1];
    logic [W-1:0]   merged [0:N-1];
    logic [N*W-1:0] packed_w;
    logic [CW-1:0]  xfer_q;
    logic           fifo_full;
    logic           fifo_empty;
    logic           in_ready;
    logic           accept;
    logic           pop;

    // in_ready comes straight from the FIFO state flops, so out_ready never
    // reaches it combinationally.
    assign in_ready = !fifo_full;
    assign accept   = bus.in_valid && in_ready;
    assign pop      = !fifo_empty && bus.out_ready;

    always_comb begin
        packed_w = '0;
        for (int i = 0; i < N; i++) begin
            merged[i] = bus.in_mask[i] ? bus.in_data[i] : hold_q[i];
            packed_w[i*W +: W] = merged[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= merged[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_q <= '0;
        end else if (pop) begin
            xfer_q <= xfer_q + CW'(1);
        end
    end

    packed_skid_fifo #(
        .DW (N*W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (packed_w),
        .pop   (pop),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = !fifo_empty;
    assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_unpacked_array_packer.sv
// Testbench for unpacked_array_packer. Two instances share one stimulus
// stream: dut_a with CW=16 and dut_b with CW=3, so counter wrap-around is
// exercised within a short run.
module tb_unpacked_array_packer;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int CWB = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    unpacked_array_packer_if #(.N(N), .W(W), .CW(CW))  ifa ();
    unpacked_array_packer_if #(.N(N), .W(W), .CW(CWB)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.out_ready = ifa.out_ready;
    for (genvar g = 0; g < N; g++) begin : g_mirror
        assign ifb.in_data[g] = ifa.in_data[g];
        assign ifb.in_mask[g] = ifa.in_mask[g];
    end

    unpacked_array_packer #(.N(N), .W(W), .CW(CW)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    unpacked_array_packer #(.N(N), .W(W), .CW(CWB)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of packed words, the held lanes, a count of
    // completed output transfers and the last word that left the queue.
    logic [N*W-1:0] m_q [$];
    logic [W-1:0]   m_hold [0:N-1];
    logic [N*W-1:0] m_last;
    logic [N*W-1:0] m_word;
    int unsigned    m_count;
    bit             m_in_ready;
    bit             m_live = 1'b0;
    bit             m_acc;
    bit             m_pop;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < N; i++) m_hold[i] = '0;
            m_last     = '0;
            m_count    = 0;
            m_in_ready = 1'b1;
            m_live     = 1'b1;
        end else if (m_live) begin
            m_acc = ifa.in_valid && m_in_ready;
            m_pop = (m_q.size() > 0) && ifa.out_ready;
            if (m_pop) begin
                m_last = m_q.pop_front();
                m_count++;
            end
            if (m_acc) begin
                m_word = '0;
                for (int i = 0; i < N; i++) begin
                    if (ifa.in_mask[i]) m_hold[i] = ifa.in_data[i];
                    m_word = m_word | ((N*W)'(m_hold[i]) << (W*i));
                end
                m_q.push_back(m_word);
            end
            m_in_ready = (m_q.size() < 2);
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("in_ready",   64'(ifa.in_ready),  64'(m_in_ready));
            chk("out_valid",  64'(ifa.out_valid), 64'(m_q.size() > 0));
            chk("out_data",   64'(ifa.out_data),  64'((m_q.size() > 0) ? m_q[0] : m_last));
            chk("xfer_count", 64'(ifa.xfer_count), 64'(m_count % 65536));
            chk("b_out_data", 64'(ifb.out_data),  64'((m_q.size() > 0) ? m_q[0] : m_last));
            chk("b_xfer_count", 64'(ifb.xfer_count), 64'(m_count % 8));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // lanes: lane i in bits [i*W +: W]; mask bit i selects lane i
    task automatic set_word(input logic v, input logic [N*W-1:0] lanes, input logic [N-1:0] mask);
        ifa.in_valid = v;
        for (int i = 0; i < N; i++) begin
            ifa.in_data[i] = lanes[i*W +: W];
            ifa.in_mask[i] = mask[i];
        end
    endtask

    task automatic send(input string name, input logic [N*W-1:0] lanes, input logic [N-1:0] mask);
        bit rdy;
        bit done;
        done = 1'b0;
        set_word(1'b1, lanes, mask);
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = ifa.in_ready;
            step();
            if (rdy) done = 1'b1;
        end
        chk({name, "_accept_timeout"}, 64'(done), 64'(1));
        set_word(1'b0, lanes, mask);
    endtask

    int dut_acc;

    initial begin
        reset = 1'b1;
        ifa.out_ready = 1'b0;
        set_word(1'b0, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_out_valid", 64'(ifa.out_valid), 64'(0));
        chk("rst_in_ready",  64'(ifa.in_ready),  64'(1));
        chk("rst_out_data",  64'(ifa.out_data),  64'(0));
        chk("rst_xfer",      64'(ifa.xfer_count), 64'(0));

        // Full-mask word then partial-mask merge
        ifa.out_ready = 1'b1;
        set_word(1'b1, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1111);
        step();
        set_word(1'b1, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 4'b0101);
        chk("t1_out_valid", 64'(ifa.out_valid), 64'(1));
        chk("t1_out_data",  64'(ifa.out_data),  64'(32'h44332211));
        step();
        set_word(1'b0, '0, '0);
        chk("t2_xfer",     64'(ifa.xfer_count), 64'(1));
        chk("t2_out_data", 64'(ifa.out_data),   64'(32'h44CC22AA));
        step();
        chk("t2_xfer_after", 64'(ifa.xfer_count), 64'(2));
        chk("t2_empty",      64'(ifa.out_valid),  64'(0));

        // Back-pressure: two accepted, third held off
        ifa.out_ready = 1'b0;
        send("t3_w0", 32'h0403_0201, 4'b1111);
        send("t3_w1", 32'h1413_1211, 4'b1111);
        chk("t3_full_in_ready", 64'(ifa.in_ready), 64'(0));
        set_word(1'b1, 32'h2423_2221, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_held_in_ready", 64'(ifa.in_ready), 64'(0));
            chk("t3_held_out_data", 64'(ifa.out_data), 64'(32'h0403_0201));
        end
        ifa.out_ready = 1'b1;
        step();
        chk("t3_second", 64'(ifa.out_data), 64'(32'h1413_1211));
        step();
        set_word(1'b0, '0, '0);
        chk("t3_third", 64'(ifa.out_data), 64'(32'h2423_2221));
        step();
        chk("t3_drained", 64'(ifa.out_valid), 64'(0));

        // Sustained throughput after a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        ifa.out_ready = 1'b1;
        dut_acc = 0;
        for (int k = 0; k < 100; k++) begin
            set_word(1'b1, $urandom, 4'($urandom_range(0, 15)));
            if (ifa.in_ready) dut_acc++;
            step();
            chk("t4_stream_valid", 64'(ifa.out_valid), 64'(1));
        end
        set_word(1'b0, '0, '0);
        step();
        chk("t4_accepts", 64'(dut_acc),          64'(100));
        chk("t4_xfer",    64'(ifa.xfer_count),   64'(100));
        chk("t4_xfer_b",  64'(ifb.xfer_count),   64'(4));

        // Reset while full
        ifa.out_ready = 1'b0;
        send("t5_w0", 32'hDEAD_BEEF, 4'b1111);
        send("t5_w1", 32'h0BAD_F00D, 4'b1111);
        set_word(1'b1, 32'h5555_AAAA, 4'b1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_word(1'b0, '0, '0);
        chk("t5_out_valid", 64'(ifa.out_valid),  64'(0));
        chk("t5_in_ready",  64'(ifa.in_ready),   64'(1));
        chk("t5_xfer",      64'(ifa.xfer_count), 64'(0));
        chk("t5_out_data",  64'(ifa.out_data),   64'(0));
        send("t5_zero", 32'hFFFF_FFFF, 4'b0000);
        chk("t5_zero_mask", 64'(ifa.out_data),   64'(32'h0000_0000));
        chk("t5_zero_valid", 64'(ifa.out_valid), 64'(1));

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            set_word(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            ifa.out_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        set_word(1'b0, '0, '0);
        ifa.out_ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unpacked_array_packer.md
Name: unpacked_array_packer

Overview:
- Receive side of the unpacked-array port path. Accepts an unpacked array of N lanes, each W bits wide, together with a per-lane unpacked update mask.
- Merges masked lanes with held lane values and packs the result into one flat vector.
- Buffers results in a 2-entry skid FIFO with valid/ready on both sides.
- Sits downstream of producers that drive unpacked-array ports and feeds consumers that expect packed buses. Also serves as the test vehicle for unpacked-array input ranges.

Parameters:
- N, 4, number of lanes (unpacked dimension, declared [0:N-1]); N >= 1.
- W, 8, bits per lane; W >= 1.
- CW, 16, width of the transfer counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W x [0:N-1]  unpacked lane array, logic [W-1:0] in_data [0:N-1].
- in_mask  input  1 x [0:N-1]  unpacked update mask; 1 = take in_data[i], 0 = reuse held lane i.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  N*W  packed result, logic [N*W-1:0].
- xfer_count  output  CW  number of completed output handshakes, modulo 2^CW.

Behaviour:
- Reset: the synchronous active-high reset (clock port `clock`, reset port `reset`) is already decided. On reset:
  - FIFO emptied; out_valid=0; in_ready=1.
  - out_data=0 (FIFO head storage cleared).
  - xfer_count=0.
  - All lane hold registers cleared to 0.
- Reset has priority over every other event. An in-flight word is discarded. No handshake completes in the reset cycle.
- Accept: input handshake = in_valid & in_ready. On accept:
  - Merged lane i = in_mask[i] ? in_data[i] : hold[i].
  - hold[i] is updated to merged lane i.
  - The packed word is pushed into the FIFO.
- Packing rule: out_data[i*W +: W] = merged lane i. Unpacked index 0 maps to the LSBs; index N-1 maps to the MSBs. This is an index-to-index mapping, not a positional one.
- Latency: a word accepted in cycle t is visible with out_valid=1 in cycle t+1. There is no combinational path from in_* to out_*.
- in_ready is registered: in_ready = (FIFO occupancy < 2). There is no combinational path from out_ready to in_ready.
- out_valid = (occupancy > 0). out_data = FIFO head. out_data is stable while out_valid & !out_ready.
- Output handshake = out_valid & out_ready. It pops the head and increments xfer_count; the counter wraps from 2^CW-1 to 0.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Legal at occupancy 1 and 2; at occupancy 2 in_ready is 0, so no push occurs.
  - At occupancy 1 the new word becomes head in the next cycle.
- Full (occupancy 2): in_ready=0, and in_data is ignored even if in_valid=1. Hold registers update only on accept.
- Empty: out_valid=0 and out_data holds its last value; consumers must not sample it.
- in_mask all-zeros is legal: the block emits the current hold contents.
- Sustained throughput is 1 word/cycle when out_ready is held high.
- Protocol: once in_valid is asserted it is not required to stay asserted; the block imposes no stickiness. out_valid, once raised, stays high until popped.
- State: occupancy {EMPTY, ONE, FULL}, plus a read pointer and write pointer (1 bit each).

Decomposition:
- Package unpacked_array_pkg:
  - Default N/W/CW localparams.
  - Typedef lane_t (logic [W-1:0]) for default sizes.
  - Function pack_lanes for the reference model.
- Sub-module packed_skid_fifo:
  - Parameters DW=N*W, depth fixed at 2.
  - Ports clock, reset, push, din, pop, dout, full, empty.
  - The top level holds the merge logic, hold registers and counter.

Test Plan (N=4, W=8):
- Reset, then in_data={8'h11,8'h22,8'h33,8'h44} (index 0..3), mask=4'b1111, out_ready=1 -> next cycle out_valid=1, out_data=32'h44332211, xfer_count becomes 1.
- After the above, send in_data={8'hAA,8'hBB,8'hCC,8'hDD} with mask[0]=1, mask[2]=1, others 0 -> out_data=32'h44CC22AA.
- out_ready=0, offer 3 words back-to-back -> first two accepted; in_ready=0 from the cycle after the 2nd accept; the third is held off. Raise out_ready -> words emerge in order, one per cycle, and the third is then accepted.
- Continuous in_valid=1/out_ready=1 for 100 cycles with random data -> 100 accepts, out_valid continuous from cycle 1, xfer_count=100, and order matches the model.
- Assert reset while FIFO is FULL with out_ready=0 -> next cycle out_valid=0, in_ready=1, xfer_count=0, out_data=0. A following mask=4'b0000 word yields out_data=32'h00000000.
- Force xfer_count to 16'hFFFF (CW=16) and complete one output handshake -> xfer_count=0.
